deca_vip_sysid_checker: RTL and testbench

//  Avalon-MM read master sitting directly downstream of the system-ID slave.

---
 rtl/deca_vip_sysid_checker_if.sv | 22 ++
 rtl/deca_vip_sysid_checker.sv | 206 ++++++++++++++++++++
 tb/tb_deca_vip_sysid_checker.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/deca_vip_sysid_checker_if.sv
// Avalon-MM read-only link between the sysid checker (master) and the
// system-ID slave it interrogates.
interface deca_vip_sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/deca_vip_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words and
// flags whether they match the build-time expected values.
module deca_vip_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1449984792,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  deca_vip_sysid_checker_if.master avm,
  output logic                     busy,
  output logic                     done,
  output logic                     id_ok,
  output logic                     ts_ok,
  output logic                     match,
  output logic                     timeout_err,
  output logic [31:0]              id_value,
  output logic [31:0]              ts_value
);

  typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FIN} state_t;

  localparam logic [1:0]  LAT_LAST   = 2'(READ_LATENCY);
  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        started_q, started_d;
  logic        read_q, read_d;
  logic        addr_q, addr_d;
  logic [15:0] stall_q, stall_d;
  logic [1:0]  lat_q, lat_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic        id_pend_q, id_pend_d;
  logic        ts_pend_q, ts_pend_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        accept;
  logic        launch;

  always_comb begin
    state_d    = state_q;
    started_d  = 1'b1;
    read_d     = read_q;
    addr_d     = addr_q;
    stall_d    = stall_q;
    lat_d      = lat_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    id_pend_d  = 1'b0;
    ts_pend_d  = 1'b0;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    accept     = read_q & ~avm.avm_waitrequest;
    launch     = start | ((state_q == IDLE) & AUTO_START & ~started_q);

    // A captured word is judged one cycle after it lands, so done never races the flags.
    if (id_pend_q) id_ok_d = (id_value_q == EXPECTED_ID);
    if (ts_pend_q) ts_ok_d = (ts_value_q == EXPECTED_TS);

    case (state_q)
      IDLE, FIN: begin
        if (launch) begin
          state_d    = RD_ID;
          read_d     = 1'b1;
          addr_d     = 1'b0;
          stall_d    = '0;
          lat_d      = '0;
          id_value_d = '0;
          ts_value_d = '0;
          id_ok_d    = 1'b0;
          ts_ok_d    = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      RD_ID: begin
        if (accept) begin
          stall_d = '0;
          if (READ_LATENCY == 0) begin
            id_value_d = avm.avm_readdata;
            id_pend_d  = 1'b1;
            addr_d     = 1'b1;
            state_d    = RD_TS;
          end else begin
            read_d  = 1'b0;
            lat_d   = 2'd1;
            state_d = LAT_ID;
          end
        end else if (stall_q == STALL_LAST) begin
          read_d    = 1'b0;
          stall_d   = '0;
          timeout_d = 1'b1;
          state_d   = FIN;
        end else begin
          stall_d = stall_q + 16'd1;
        end
      end
      LAT_ID: begin
        if (lat_q == LAT_LAST) begin
          id_value_d = avm.avm_readdata;
          id_pend_d  = 1'b1;
          lat_d      = '0;
          read_d     = 1'b1;
          addr_d     = 1'b1;
          state_d    = RD_TS;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      RD_TS: begin
        if (accept) begin
          stall_d = '0;
          read_d  = 1'b0;
          if (READ_LATENCY == 0) begin
            ts_value_d = avm.avm_readdata;
            ts_pend_d  = 1'b1;
            state_d    = FIN;
          end else begin
            lat_d   = 2'd1;
            state_d = LAT_TS;
          end
        end else if (stall_q == STALL_LAST) begin
          read_d    = 1'b0;
          stall_d   = '0;
          timeout_d = 1'b1;
          state_d   = FIN;
        end else begin
          stall_d = stall_q + 16'd1;
        end
      end
      LAT_TS: begin
        if (lat_q == LAT_LAST) begin
          ts_value_d = avm.avm_readdata;
          ts_pend_d  = 1'b1;
          lat_d      = '0;
          state_d    = FIN;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
      end
    endcase

    busy_d = (state_d == RD_ID) | (state_d == LAT_ID) |
             (state_d == RD_TS) | (state_d == LAT_TS);
    done_d = (state_d == FIN) & ~id_pend_d & ~ts_pend_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      started_q  <= 1'b0;
      read_q     <= 1'b0;
      addr_q     <= 1'b0;
      stall_q    <= '0;
      lat_q      <= '0;
      id_value_q <= '0;
      ts_value_q <= '0;
      id_pend_q  <= 1'b0;
      ts_pend_q  <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      started_q  <= started_d;
      read_q     <= read_d;
      addr_q     <= addr_d;
      stall_q    <= stall_d;
      lat_q      <= lat_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
      id_pend_q  <= id_pend_d;
      ts_pend_q  <= ts_pend_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign avm.avm_read    = read_q;
  assign avm.avm_address = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign id_ok           = id_ok_q;
  assign ts_ok           = ts_ok_q;
  assign timeout_err     = timeout_q;
  assign match           = done_q & id_ok_q & ts_ok_q & ~timeout_q;
  assign id_value        = id_value_q;
  assign ts_value        = ts_value_q;

endmodule

// File: tb/tb_deca_vip_sysid_checker.sv
// Bench: instance 0 is zero-latency/auto-start, instance 1 is latency-2,
// 16-cycle timeout, manual start; both talk to a behavioural sysid slave.
`timescale 1ns/1ps
module tb_deca_vip_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1449984792;
  localparam int LAT_A = 0;
  localparam int TMO_A = 255;
  localparam int LAT_B = 2;
  localparam int TMO_B = 16;
  localparam int DONE_LIMIT = 600;

  typedef struct {
    int          inst;
    logic [31:0] id_word;
    logic [31:0] ts_word;
    int          id_stall;
    int          ts_stall;
    logic        exp_id_ok;
    logic        exp_ts_ok;
    logic        exp_match;
    logic        exp_tmo;
    logic [31:0] exp_id_val;
    logic [31:0] exp_ts_val;
    int          exp_cycles;
    int          exp_rd0;
    int          exp_rd1;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_s [2];
  logic        busy_s [2];
  logic        done_s [2];
  logic        id_ok_s [2];
  logic        ts_ok_s [2];
  logic        match_s [2];
  logic        tmo_s [2];
  logic [31:0] id_val_s [2];
  logic [31:0] ts_val_s [2];
  logic        read_s [2];
  logic        addr_s [2];
  logic        wait_s [2];
  logic [31:0] rdata_s [2];

  logic [31:0] slv_id [2];
  logic [31:0] slv_ts [2];
  int          id_stall_cfg [2];
  int          ts_stall_cfg [2];
  int          stall_seen [2] = '{0, 0};
  int          acc_cyc [2] = '{-1000, -1000};
  logic        acc_addr [2] = '{1'b0, 1'b0};
  int          acc0_cnt [2] = '{0, 0};
  int          acc1_cnt [2] = '{0, 0};
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clock = ~clock;

  deca_vip_sysid_checker_if avm_a ();
  deca_vip_sysid_checker_if avm_b ();

  assign read_s[0] = avm_a.avm_read;
  assign addr_s[0] = avm_a.avm_address;
  assign read_s[1] = avm_b.avm_read;
  assign addr_s[1] = avm_b.avm_address;
  assign avm_a.avm_waitrequest = wait_s[0];
  assign avm_a.avm_readdata    = rdata_s[0];
  assign avm_b.avm_waitrequest = wait_s[1];
  assign avm_b.avm_readdata    = rdata_s[1];

  deca_vip_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(LAT_A),
    .TIMEOUT_CYCLES(TMO_A), .AUTO_START(1'b1)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_s[0]), .avm(avm_a),
    .busy(busy_s[0]), .done(done_s[0]), .id_ok(id_ok_s[0]), .ts_ok(ts_ok_s[0]),
    .match(match_s[0]), .timeout_err(tmo_s[0]),
    .id_value(id_val_s[0]), .ts_value(ts_val_s[0])
  );

  deca_vip_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(LAT_B),
    .TIMEOUT_CYCLES(TMO_B), .AUTO_START(1'b0)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_s[1]), .avm(avm_b),
    .busy(busy_s[1]), .done(done_s[1]), .id_ok(id_ok_s[1]), .ts_ok(ts_ok_s[1]),
    .match(match_s[1]), .timeout_err(tmo_s[1]),
    .id_value(id_val_s[1]), .ts_value(ts_val_s[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT_A : LAT_B;
  endfunction

  // Slave: stalls the configured number of cycles per word, then returns the
  // word exactly READ_LATENCY cycles after the accept and garbage otherwise.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      wait_s[k]  = read_s[k] &&
                   (stall_seen[k] < (addr_s[k] ? ts_stall_cfg[k] : id_stall_cfg[k]));
      rdata_s[k] = 32'hDEAD_BEEF;
      if (lat_of(k) == 0) begin
        if (read_s[k]) rdata_s[k] = addr_s[k] ? slv_ts[k] : slv_id[k];
      end else if (cyc == acc_cyc[k] + lat_of(k)) begin
        rdata_s[k] = acc_addr[k] ? slv_ts[k] : slv_id[k];
      end
    end
  end

  always @(posedge clock) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (read_s[k] && !wait_s[k]) begin
        acc_cyc[k]    <= cyc;
        acc_addr[k]   <= addr_s[k];
        stall_seen[k] <= 0;
        if (addr_s[k]) acc1_cnt[k] <= acc1_cnt[k] + 1;
        else           acc0_cnt[k] <= acc0_cnt[k] + 1;
      end else if (read_s[k]) begin
        stall_seen[k] <= stall_seen[k] + 1;
      end else begin
        stall_seen[k] <= 0;
      end
    end
  end

  // Reference model: outcome of one check from the read/timeout rules alone.
  function automatic vec_t mk(input int inst, input logic [31:0] idw,
                              input logic [31:0] tsw, input int s1, input int s2);
    vec_t v;
    int   lat;
    int   tmo;
    bit   id_rd;
    bit   ts_rd;
    v.inst     = inst;
    v.id_word  = idw;
    v.ts_word  = tsw;
    v.id_stall = s1;
    v.ts_stall = s2;
    lat   = (inst == 0) ? LAT_A : LAT_B;
    tmo   = (inst == 0) ? TMO_A : TMO_B;
    id_rd = (s1 < tmo);
    ts_rd = id_rd && (s2 < tmo);
    v.exp_tmo    = !ts_rd;
    v.exp_id_val = id_rd ? idw : 32'h0;
    v.exp_ts_val = ts_rd ? tsw : 32'h0;
    v.exp_id_ok  = id_rd && (idw == EXP_ID);
    v.exp_ts_ok  = ts_rd && (tsw == EXP_TS);
    v.exp_match  = v.exp_id_ok && v.exp_ts_ok && !v.exp_tmo;
    if (!id_rd)      v.exp_cycles = tmo;
    else if (!ts_rd) v.exp_cycles = s1 + 1 + lat + tmo;
    else             v.exp_cycles = s1 + s2 + 2 * lat + 3;
    v.exp_rd0 = id_rd ? 1 : 0;
    v.exp_rd1 = ts_rd ? 1 : 0;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkReset(input int k, input string tag);
    checkOutput($sformatf("%s%0d.busy", tag, k), busy_s[k], 0);
    checkOutput($sformatf("%s%0d.done", tag, k), done_s[k], 0);
    checkOutput($sformatf("%s%0d.id_ok", tag, k), id_ok_s[k], 0);
    checkOutput($sformatf("%s%0d.ts_ok", tag, k), ts_ok_s[k], 0);
    checkOutput($sformatf("%s%0d.match", tag, k), match_s[k], 0);
    checkOutput($sformatf("%s%0d.tmo", tag, k), tmo_s[k], 0);
    checkOutput($sformatf("%s%0d.id_val", tag, k), id_val_s[k], 0);
    checkOutput($sformatf("%s%0d.ts_val", tag, k), ts_val_s[k], 0);
    checkOutput($sformatf("%s%0d.read", tag, k), read_s[k], 0);
    checkOutput($sformatf("%s%0d.addr", tag, k), addr_s[k], 0);
  endtask

  // Counts edges after the start edge until done is seen (sampled on negedges).
  task automatic waitDone(input int k, output int n);
    n = 0;
    while (!done_s[k] && n < DONE_LIMIT) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic applyStimulus(input vec_t v, output int n, output int d0, output int d1);
    int k;
    int a0;
    int a1;
    k = v.inst;
    @(negedge clock);
    slv_id[k]       = v.id_word;
    slv_ts[k]       = v.ts_word;
    id_stall_cfg[k] = v.id_stall;
    ts_stall_cfg[k] = v.ts_stall;
    a0 = acc0_cnt[k];
    a1 = acc1_cnt[k];
    start_s[k] = 1'b1;
    @(negedge clock);
    start_s[k] = 1'b0;
    waitDone(k, n);
    d0 = acc0_cnt[k] - a0;
    d1 = acc1_cnt[k] - a1;
  endtask

  task automatic checkVector(input int i, input vec_t v, input int n, input int d0, input int d1);
    int k;
    k = v.inst;
    checkOutput($sformatf("v%0d.cycles", i), n, v.exp_cycles);
    checkOutput($sformatf("v%0d.done", i), done_s[k], 1);
    checkOutput($sformatf("v%0d.busy", i), busy_s[k], 0);
    checkOutput($sformatf("v%0d.read", i), read_s[k], 0);
    checkOutput($sformatf("v%0d.id_ok", i), id_ok_s[k], v.exp_id_ok);
    checkOutput($sformatf("v%0d.ts_ok", i), ts_ok_s[k], v.exp_ts_ok);
    checkOutput($sformatf("v%0d.match", i), match_s[k], v.exp_match);
    checkOutput($sformatf("v%0d.tmo", i), tmo_s[k], v.exp_tmo);
    checkOutput($sformatf("v%0d.id_val", i), id_val_s[k], v.exp_id_val);
    checkOutput($sformatf("v%0d.ts_val", i), ts_val_s[k], v.exp_ts_val);
    checkOutput($sformatf("v%0d.reads0", i), d0, v.exp_rd0);
    checkOutput($sformatf("v%0d.reads1", i), d1, v.exp_rd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    int   n;
    int   d0;
    int   d1;
    int   a0;
    int   a1;

    vecs.push_back(mk(0, EXP_ID, EXP_TS, 0, 0));
    vecs.push_back(mk(0, EXP_ID, 32'h5666_6666, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0001, EXP_TS, 3, 2));
    vecs.push_back(mk(0, EXP_ID, EXP_TS, 0, 254));
    vecs.push_back(mk(1, EXP_ID, EXP_TS, 0, 10));
    vecs.push_back(mk(1, EXP_ID, EXP_TS, 100000, 0));
    vecs.push_back(mk(1, EXP_ID, EXP_TS, 15, 0));
    vecs.push_back(mk(1, EXP_ID, EXP_TS, 16, 0));
    vecs.push_back(mk(1, 32'hCAFE_0000, EXP_TS, 2, 16));
    vecs.push_back(mk(1, EXP_ID, 32'h1234_5678, 0, 0));
    for (int r = 0; r < 14; r++) begin
      logic [31:0] idw;
      logic [31:0] tsw;
      idw = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom();
      tsw = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom();
      vecs.push_back(mk($urandom_range(0, 1), idw, tsw,
                        $urandom_range(0, 20), $urandom_range(0, 20)));
    end

    for (int k = 0; k < 2; k++) begin
      start_s[k]      = 1'b0;
      slv_id[k]       = EXP_ID;
      slv_ts[k]       = EXP_TS;
      id_stall_cfg[k] = 0;
      ts_stall_cfg[k] = 0;
    end

    // Power-on reset, then auto-start on instance 0 only.
    repeat (3) @(negedge clock);
    for (int k = 0; k < 2; k++) checkReset(k, "por");
    reset_n = 1'b1;
    @(negedge clock);
    waitDone(0, n);
    checkOutput("auto.cycles", n, 3);
    checkOutput("auto.match", match_s[0], 1);
    checkOutput("auto.id_ok", id_ok_s[0], 1);
    checkOutput("auto.ts_ok", ts_ok_s[0], 1);
    checkOutput("auto.reads0", acc0_cnt[0], 1);
    checkOutput("auto.reads1", acc1_cnt[0], 1);
    checkOutput("auto.b_busy", busy_s[1], 0);
    checkOutput("auto.b_read", read_s[1], 0);
    checkOutput("auto.b_done", done_s[1], 0);

    // Start while busy is ignored; start after done clears and re-runs.
    @(negedge clock);
    ts_stall_cfg[0] = 4;
    a0 = acc0_cnt[0];
    a1 = acc1_cnt[0];
    start_s[0] = 1'b1;
    @(negedge clock);
    start_s[0] = 1'b0;
    @(negedge clock);
    start_s[0] = 1'b1;
    @(negedge clock);
    start_s[0] = 1'b0;
    waitDone(0, n);
    checkOutput("busy_start.cycles", n + 2, 7);
    checkOutput("busy_start.reads0", acc0_cnt[0] - a0, 1);
    checkOutput("busy_start.reads1", acc1_cnt[0] - a1, 1);
    checkOutput("busy_start.match", match_s[0], 1);
    @(negedge clock);
    slv_id[0]       = 32'h0000_0005;
    ts_stall_cfg[0] = 0;
    a0 = acc0_cnt[0];
    a1 = acc1_cnt[0];
    start_s[0] = 1'b1;
    @(negedge clock);
    start_s[0] = 1'b0;
    checkOutput("rerun.clr_done", done_s[0], 0);
    checkOutput("rerun.clr_ts_ok", ts_ok_s[0], 0);
    checkOutput("rerun.clr_ts_val", ts_val_s[0], 0);
    checkOutput("rerun.busy", busy_s[0], 1);
    waitDone(0, n);
    checkOutput("rerun.cycles", n, 3);
    checkOutput("rerun.id_ok", id_ok_s[0], 0);
    checkOutput("rerun.ts_ok", ts_ok_s[0], 1);
    checkOutput("rerun.id_val", id_val_s[0], 32'h0000_0005);
    checkOutput("rerun.match", match_s[0], 0);
    checkOutput("rerun.reads0", acc0_cnt[0] - a0, 1);
    checkOutput("rerun.reads1", acc1_cnt[0] - a1, 1);

    // Reset asserted while the timestamp read is stalled.
    @(negedge clock);
    slv_id[0]       = EXP_ID;
    ts_stall_cfg[0] = 50;
    start_s[0] = 1'b1;
    @(negedge clock);
    start_s[0] = 1'b0;
    n = 0;
    while (!(read_s[0] && addr_s[0]) && n < 50) begin
      @(negedge clock);
      n++;
    end
    checkOutput("rst.in_rd_ts", read_s[0] && addr_s[0], 1);
    repeat (3) @(negedge clock);
    checkOutput("rst.id_ok_before", id_ok_s[0], 1);
    #1 reset_n = 1'b0;
    #1 checkReset(0, "rst");
    ts_stall_cfg[0] = 0;
    a0 = acc0_cnt[0];
    a1 = acc1_cnt[0];
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    waitDone(0, n);
    checkOutput("rst.cycles", n, 3);
    checkOutput("rst.match", match_s[0], 1);
    checkOutput("rst.reads0", acc0_cnt[0] - a0, 1);
    checkOutput("rst.reads1", acc1_cnt[0] - a1, 1);

    // Table of directed and random checks against the reference model.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], n, d0, d1);
      checkVector(i, vecs[i], n, d0, d1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
